// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the EX stage (port 0) and an
// auxiliary unit (port 1) using round-robin arbitration.
//
// Ports:
//   Clk, Reset_N               clock, async active-low reset
//   Req{0,1}Valid/Ready        request handshake per port
//   Req{0,1}In0/In1/Op         request operands and opcode
//   AluIn0/AluIn1/AluOp        registered operands to the ALU
//   AluOut/AluOF               ALU result and raw overflow
//   RspValid/RspReady          per-port one-hot response handshake
//   RspData/RspOF              held result and masked overflow
//   Busy                       high whenever not IDLE
//   OfTrap/OfTrapSrc           only with ALU_ARB_OF_TRAP_EN: one-cycle
//                              overflow pulse and the port that caused it
module alu_share_arb #(
    parameter int              DATA_W  = 32,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] NOP_OP  = 4'h0,
    parameter logic [OP_W-1:0] ADDS_OP = 4'h2,
    parameter logic [OP_W-1:0] SUBS_OP = 4'h3
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [DATA_W-1:0] Req0In0,
    input  logic [DATA_W-1:0] Req0In1,
    input  logic [OP_W-1:0]   Req0Op,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [DATA_W-1:0] Req1In0,
    input  logic [DATA_W-1:0] Req1In1,
    input  logic [OP_W-1:0]   Req1Op,
    output logic [DATA_W-1:0] AluIn0,
    output logic [DATA_W-1:0] AluIn1,
    output logic [OP_W-1:0]   AluOp,
    input  logic [DATA_W-1:0] AluOut,
    input  logic              AluOF,
    output logic [1:0]        RspValid,
    input  logic [1:0]        RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              RspOF,
`ifdef ALU_ARB_OF_TRAP_EN
    output logic              OfTrap,
    output logic              OfTrapSrc,
`endif
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic [DATA_W-1:0] in0_q, in0_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_of_q, rsp_of_d;

    logic win0, win1;
    logic of_masked;

    // On contention the port that did not win last time takes the grant.
    assign win0 = Req0Valid && (!Req1Valid || last_q);
    assign win1 = Req1Valid && (!Req0Valid || !last_q);

    // OF is only meaningful for the signed add/subtract opcodes.
    assign of_masked = AluOF && ((op_q == ADDS_OP) || (op_q == SUBS_OP));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_of_d    = rsp_of_q;
        Req0Ready   = 1'b0;
        Req1Ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                Req0Ready = win0;
                Req1Ready = win1;
                if (win0 || win1) begin
                    in0_d   = win1 ? Req1In0 : Req0In0;
                    in1_d   = win1 ? Req1In1 : Req0In1;
                    op_d    = win1 ? Req1Op : Req0Op;
                    last_d  = win1;
                    gnt_d   = win1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = AluOut;
                rsp_of_d    = of_masked;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                in0_d       = '0;
                in1_d       = '0;
                op_d        = NOP_OP;
                state_d     = RESP;
            end
            RESP: begin
                if (RspReady[gnt_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            op_q        <= NOP_OP;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_of_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_of_q    <= rsp_of_d;
        end
    end

`ifdef ALU_ARB_OF_TRAP_EN
    logic trap_q, trap_src_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            trap_q     <= 1'b0;
            trap_src_q <= 1'b0;
        end else begin
            trap_q <= (state_q == EXEC) && of_masked;
            if ((state_q == EXEC) && of_masked) begin
                trap_src_q <= gnt_q;
            end
        end
    end

    assign OfTrap    = trap_q;
    assign OfTrapSrc = trap_src_q;
`endif

    assign AluIn0   = in0_q;
    assign AluIn1   = in1_q;
    assign AluOp    = op_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspOF    = rsp_of_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb.
// A tiny behavioural ALU stands in for the shared ALU instance.
module tb_alu_share_arb;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDU = 4'h1;
    localparam logic [3:0] OP_ADDS = 4'h2;
    localparam logic [3:0] OP_SUBS = 4'h3;

    logic        Clk;
    logic        Reset_N;
    logic        Req0Valid, Req0Ready;
    logic [31:0] Req0In0, Req0In1;
    logic [3:0]  Req0Op;
    logic        Req1Valid, Req1Ready;
    logic [31:0] Req1In0, Req1In1;
    logic [3:0]  Req1Op;
    logic [31:0] AluIn0, AluIn1;
    logic [3:0]  AluOp;
    logic [31:0] AluOut;
    logic        AluOF;
    logic [1:0]  RspValid, RspReady;
    logic [31:0] RspData;
    logic        RspOF;
    logic        Busy;
`ifdef ALU_ARB_OF_TRAP_EN
    logic        OfTrap, OfTrapSrc;
`endif

    int n_run  = 0;
    int n_fail = 0;

    alu_share_arb dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .Req0Valid (Req0Valid),
        .Req0Ready (Req0Ready),
        .Req0In0   (Req0In0),
        .Req0In1   (Req0In1),
        .Req0Op    (Req0Op),
        .Req1Valid (Req1Valid),
        .Req1Ready (Req1Ready),
        .Req1In0   (Req1In0),
        .Req1In1   (Req1In1),
        .Req1Op    (Req1Op),
        .AluIn0    (AluIn0),
        .AluIn1    (AluIn1),
        .AluOp     (AluOp),
        .AluOut    (AluOut),
        .AluOF     (AluOF),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspData   (RspData),
        .RspOF     (RspOF),
`ifdef ALU_ARB_OF_TRAP_EN
        .OfTrap    (OfTrap),
        .OfTrapSrc (OfTrapSrc),
`endif
        .Busy      (Busy)
    );

    // ADDU reports its carry on OF so the arbiter's masking is exercised.
    logic [32:0] sum33;
    logic [31:0] diff;
    always_comb begin
        sum33  = {1'b0, AluIn0} + {1'b0, AluIn1};
        diff   = AluIn0 - AluIn1;
        AluOut = 32'h0;
        AluOF  = 1'b0;
        case (AluOp)
            OP_ADDU: begin
                AluOut = sum33[31:0];
                AluOF  = sum33[32];
            end
            OP_ADDS: begin
                AluOut = sum33[31:0];
                AluOF  = (AluIn0[31] == AluIn1[31]) && (sum33[31] != AluIn0[31]);
            end
            OP_SUBS: begin
                AluOut = diff;
                AluOF  = (AluIn0[31] != AluIn1[31]) && (diff[31] != AluIn0[31]);
            end
            default: ;
        endcase
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Single request on one port, with a wrong-bit RspReady cycle first.
    task automatic run_one(input logic p, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] exp_d, input logic exp_of);
        if (p) begin
            Req1Valid = 1'b1; Req1In0 = a; Req1In1 = b; Req1Op = op;
        end else begin
            Req0Valid = 1'b1; Req0In0 = a; Req0In1 = b; Req0Op = op;
        end
        #1;
        check("req_ready", 32'(p ? Req1Ready : Req0Ready), 32'd1);
        check("req_other_ready", 32'(p ? Req0Ready : Req1Ready), 32'd0);
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        check("exec_busy", 32'(Busy), 32'd1);
        check("exec_op", 32'(AluOp), 32'(op));
        check("exec_in0", AluIn0, a);
        check("exec_in1", AluIn1, b);
        check("exec_no_rsp", 32'(RspValid), 32'd0);
        tick();
        check("rsp_valid", 32'(RspValid), p ? 32'd2 : 32'd1);
        check("rsp_data", RspData, exp_d);
        check("rsp_of", 32'(RspOF), 32'(exp_of));
        check("rsp_aluop_nop", 32'(AluOp), 32'(OP_NOP));
        check("rsp_aluin0_zero", AluIn0, 32'd0);
`ifdef ALU_ARB_OF_TRAP_EN
        check("trap_pulse", 32'(OfTrap), 32'(exp_of));
        if (exp_of) check("trap_src", 32'(OfTrapSrc), 32'(p));
`endif
        RspReady = p ? 2'b01 : 2'b10;
        tick();
        check("rsp_wrong_bit_hold", 32'(RspValid), p ? 32'd2 : 32'd1);
        check("rsp_wrong_bit_data", RspData, exp_d);
`ifdef ALU_ARB_OF_TRAP_EN
        check("trap_one_cycle", 32'(OfTrap), 32'd0);
`endif
        RspReady = p ? 2'b10 : 2'b01;
        tick();
        check("rsp_cleared", 32'(RspValid), 32'd0);
        check("idle_busy", 32'(Busy), 32'd0);
        RspReady = 2'b00;
    endtask

    initial begin
        int ng;
        int nr;
        int extra_idle;
        logic last_g;

        Reset_N   = 1'b0;
        Req0Valid = 1'b0; Req0In0 = '0; Req0In1 = '0; Req0Op = OP_NOP;
        Req1Valid = 1'b0; Req1In0 = '0; Req1In1 = '0; Req1Op = OP_NOP;
        RspReady  = 2'b00;
        repeat (2) tick();

        check("rst_rspvalid", 32'(RspValid), 32'd0);
        check("rst_rspdata", RspData, 32'd0);
        check("rst_rspof", 32'(RspOF), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_aluop", 32'(AluOp), 32'(OP_NOP));
        check("rst_aluin0", AluIn0, 32'd0);
        check("rst_aluin1", AluIn1, 32'd0);
        check("rst_ready0", 32'(Req0Ready), 32'd0);
        check("rst_ready1", 32'(Req1Ready), 32'd0);

        Reset_N = 1'b1;
        tick();

        // 5 + 3 unsigned, port 0
        run_one(1'b0, 32'h0000_0005, 32'h0000_0003, OP_ADDU, 32'h0000_0008, 1'b0);
        // unsigned wrap: carry must not show up as RspOF
        run_one(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADDU, 32'h0000_0000, 1'b0);
        // signed overflow, port 1
        run_one(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADDS, 32'h8000_0000, 1'b1);

        // Contention: both valid continuously, Last=1 so port 0 starts.
        Req0Valid = 1'b1; Req0In0 = 32'd10;  Req0In1 = 32'd20; Req0Op = OP_ADDU;
        Req1Valid = 1'b1; Req1In0 = 32'd100; Req1In1 = 32'd1;  Req1Op = OP_SUBS;
        RspReady  = 2'b11;
        ng = 0; nr = 0; extra_idle = 0; last_g = 1'b0;
        #1;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            if (RspValid != 2'b00) begin
                check("cont_rsp_port", 32'(RspValid), last_g ? 32'd2 : 32'd1);
                check("cont_rsp_data", RspData, last_g ? 32'd99 : 32'd30);
                nr++;
            end
            if (Req0Ready || Req1Ready) begin
                check("cont_grant", 32'(Req1Ready), 32'(ng % 2));
                last_g = Req1Ready;
                ng++;
            end else if (!Busy) begin
                extra_idle++;
            end
            @(posedge Clk);
            #3;
        end
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        check("cont_grants", 32'(ng), 32'd6);
        @(posedge Clk);
        #3;
        check("cont_last_rsp", 32'(RspValid), 32'd2);
        check("cont_last_data", RspData, 32'd99);
        if (RspValid != 2'b00) nr++;
        check("cont_rsp_count", 32'(nr), 32'd6);
        check("cont_idle_gap", 32'(extra_idle), 32'd0);
        @(posedge Clk);
        #2;
        RspReady = 2'b00;

        // Backpressure on port 0 while port 1 keeps asking.
        Req0Valid = 1'b1; Req0In0 = 32'd1; Req0In1 = 32'd2; Req0Op = OP_ADDU;
        Req1Valid = 1'b1; Req1In0 = 32'd7; Req1In1 = 32'd2; Req1Op = OP_SUBS;
        #1;
        check("bp_grant0", 32'(Req0Ready), 32'd1);
        check("bp_no_grant1", 32'(Req1Ready), 32'd0);
        tick();
        Req0Valid = 1'b0;
        check("bp_exec_r1", 32'(Req1Ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(RspValid), 32'd1);
            check("bp_hold_data", RspData, 32'd3);
            check("bp_r1_low", 32'(Req1Ready), 32'd0);
            tick();
        end
        RspReady = 2'b01;
        #1;
        check("bp_r1_low_accept", 32'(Req1Ready), 32'd0);
        tick();
        RspReady = 2'b00;
        #1;
        check("bp_grant1_after", 32'(Req1Ready), 32'd1);
        tick();
        Req1Valid = 1'b0;
        tick();
        check("bp_rsp1_valid", 32'(RspValid), 32'd2);
        check("bp_rsp1_data", RspData, 32'd5);
        RspReady = 2'b10;
        tick();
        RspReady = 2'b00;

        // Reset during EXEC of a port 0 request.
        Req0Valid = 1'b1; Req0In0 = 32'd9; Req0In1 = 32'd9; Req0Op = OP_ADDU;
        #1;
        check("rm_grant0", 32'(Req0Ready), 32'd1);
        tick();
        Req0Valid = 1'b0;
        check("rm_exec_busy", 32'(Busy), 32'd1);
        Reset_N = 1'b0;
        #1;
        check("rm_aluop", 32'(AluOp), 32'(OP_NOP));
        check("rm_aluin0", AluIn0, 32'd0);
        check("rm_busy", 32'(Busy), 32'd0);
        check("rm_rspvalid", 32'(RspValid), 32'd0);
        check("rm_rspdata", RspData, 32'd0);
        tick();
        Reset_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rm_no_rsp", 32'(RspValid), 32'd0);
        end
        Req0Valid = 1'b1; Req0In0 = 32'd4; Req0In1 = 32'd4; Req0Op = OP_ADDU;
        Req1Valid = 1'b1;
        #1;
        check("rm_prio0", 32'(Req0Ready), 32'd1);
        check("rm_prio1", 32'(Req1Ready), 32'd0);
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        tick();
        check("rm_rsp_valid", 32'(RspValid), 32'd1);
        check("rm_rsp_data", RspData, 32'd8);
        RspReady = 2'b01;
        tick();
        RspReady = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational alu instance between two requesters: port 0 is the EX stage, port 1 is the multi-cycle/auxiliary unit.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Registers operands into the ALU, captures Out/OF, and returns the result to the granted requester.
- Sits between the pipeline EX logic and the shared ALU.

Parameters:
- DATA_W, `WORD_DATA_W (32): operand/result width.
- OP_W, `ALU_OP_W: ALU opcode width.
- NOP_OP, `ALU_OP_NOP: opcode driven to the ALU while idle.
- ADDS_OP, `ALU_OP_ADDS: signed add code; OF is valid only for this and SUBS_OP.
- SUBS_OP, `ALU_OP_SUBS: signed subtract code.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- Req0Valid  in  1  port 0 request valid.
- Req0Ready  out  1  port 0 request accepted this cycle.
- Req0In0  in  DATA_W  port 0 operand 0.
- Req0In1  in  DATA_W  port 0 operand 1.
- Req0Op  in  OP_W  port 0 opcode.
- Req1Valid  in  1  port 1 request valid.
- Req1Ready  out  1  port 1 request accepted this cycle.
- Req1In0  in  DATA_W  port 1 operand 0.
- Req1In1  in  DATA_W  port 1 operand 1.
- Req1Op  in  OP_W  port 1 opcode.
- AluIn0  out  DATA_W  to ALU In0 (registered).
- AluIn1  out  DATA_W  to ALU In1 (registered).
- AluOp  out  OP_W  to ALU Op (registered).
- AluOut  in  DATA_W  from ALU Out.
- AluOF  in  1  from ALU OF.
- RspValid  out  2  one-hot; bit n means a response is held for port n.
- RspReady  in  2  per-port response accept.
- RspData  out  DATA_W  result.
- RspOF  out  1  overflow; masked to 0 unless the op was ADDS_OP or SUBS_OP.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, Reset_N=0):
  - State IDLE, round-robin pointer Last=1 (port 0 wins first).
  - AluIn0/AluIn1 = 0, AluOp = NOP_OP.
  - RspValid = 0, RspData = 0, RspOF = 0, Busy = 0, both ReqReady = 0.
  - Reset mid-operation discards the in-flight request and any held response. No response is ever produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - ReqnReady is combinational. Only the winner sees Ready=1.
  - Winner selection: if both Valid, the port != Last wins. Otherwise the single valid port wins.
  - On handshake: latch winner's In0/In1/Op into AluIn0/AluIn1/AluOp, set Last=winner, record grant ID, go EXEC.
  - No valid request: stay IDLE and hold NOP outputs.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable.
  - At the clock edge: RspData<=AluOut; RspOF<=AluOF if the latched Op is ADDS_OP/SUBS_OP, else 0.
  - Set RspValid[grant]=1 and go RESP.
  - Restore AluOp=NOP_OP and AluIn0/AluIn1=0 at that edge.
- RESP:
  - Hold RspValid/RspData/RspOF until RspReady[grant]=1.
  - On the accept edge: clear RspValid and go IDLE.
  - RspReady on the non-granted bit is ignored.
- Latency:
  - Request handshake at edge T; RspValid high from T+2.
  - Minimum issue interval is 3 cycles (no overlap; one request in flight).
- Handshake rules:
  - Requester holds Valid and operands stable until Ready.
  - Ready is 0 in EXEC/RESP.
  - Both ports valid every cycle: grants strictly alternate.
  - A requester dropping Valid before Ready is legal; no grant occurs.
- Widths: the arbiter does no arithmetic; operands pass unmodified; RspData is a full DATA_W copy.

Optional Feature:
- Macro: ALU_ARB_OF_TRAP_EN.
- Defined:
  - Adds output OfTrap (1 bit) and output OfTrapSrc (1 bit).
  - OfTrap pulses high for exactly one cycle on the EXEC->RESP edge when the masked OF is 1.
  - OfTrapSrc = grant ID, held until the next trap.
  - RspData is still delivered unchanged.
  - Both outputs reset to 0.
- Undefined: the ports are absent and no trap logic exists. Overflow is visible only via RspOF.

Test Plan:
- Port 0 only: In0=0x00000005, In1=0x00000003, Op=ADDU, handshake at T -> RspValid=2'b01 at T+2, RspData=0x00000008, RspOF=0. AluOp returns to NOP_OP at T+2.
- Signed overflow: port 1, 0x7FFFFFFF ADDS 0x00000001 -> RspData=0x80000000, RspOF=1, RspValid=2'b10. With ALU_ARB_OF_TRAP_EN: one-cycle OfTrap=1, OfTrapSrc=1.
- OF masking: port 0, 0xFFFFFFFF ADDU 0x00000001 -> RspData=0x00000000, RspOF=0.
- Contention: both ports valid continuously, 6 requests total -> grant order 0,1,0,1,0,1. Each response is delivered before the next Ready; Busy low only one cycle between transactions.
- Backpressure: RspReady[0]=0 for 5 cycles after RspValid -> RspValid/RspData stable for 5 cycles. Port 1 Ready stays 0 throughout; port 1 is granted the cycle after the accept.
- Reset mid-op: Reset_N low during EXEC -> all outputs 0 and AluOp=NOP_OP immediately. No response after release; next request is handled normally with port 0 priority.
